mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin on simultaneous requests, 0 = fixed D-side priority.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port proc_reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port mem_read_I, input, 1, I-cache line read request.
REQ-005 SHALL have port mem_addr_I, input, [31:4], I-cache line address.
REQ-006 SHALL have port mem_rdata_I, output, 128, line data to I-cache.
REQ-007 SHALL have port mem_ready_I, output, 1, I-side completion pulse.
REQ-008 SHALL have port mem_read_D, input, 1, D-cache line read request.
REQ-009 SHALL have port mem_write_D, input, 1, D-cache line write-back request.
REQ-010 SHALL have port mem_addr_D, input, [31:4], D-cache line address.
REQ-011 SHALL have port mem_wdata_D, input, 128, D-cache write-back data.
REQ-012 SHALL have port mem_rdata_D, output, 128, line data to D-cache.
REQ-013 SHALL have port mem_ready_D, output, 1, D-side completion pulse.
REQ-014 SHALL have port mem_read, output, 1, read strobe to shared slow memory.
REQ-015 SHALL have port mem_write, output, 1, write strobe to shared slow memory.
REQ-016 SHALL have port mem_addr, output, [31:4], shared memory line address.
REQ-017 SHALL have port mem_wdata, output, 128, shared memory write data.
REQ-018 SHALL have port mem_rdata, input, 128, shared memory read data.
REQ-019 SHALL have port mem_ready, input, 1, shared memory completion pulse.
REQ-020 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, GNT_I, GNT_D, RELEASE.
REQ-022 SHALL define req_I = mem_read_I and req_D = mem_read_D | mem_write_D.
REQ-023 SHALL, in IDLE: only req_I -> GNT_I; only req_D -> GNT_D; neither -> stay in IDLE.
REQ-024 SHALL, in IDLE with both requests, grant D if RR_EN=0; if RR_EN=1, grant the side not granted last (last_gnt register).
REQ-025 SHALL, on the IDLE-exit edge, register mem_read, mem_write, mem_addr and mem_wdata from the granted side; the first memory strobe appears 1 cycle after the request is sampled.
REQ-026 SHALL, for a D grant, copy mem_write_D to mem_write and mem_read_D to mem_read; if both are set, forward the write only, suppress the read, and leave it pending for a later grant.
REQ-027 SHALL, for an I grant, drive mem_write=0 and mem_wdata=0.
REQ-028 SHALL hold the memory outputs stable in GNT_I/GNT_D until mem_ready=1, regardless of requester input changes.
REQ-029 SHALL route mem_ready combinationally to mem_ready_I (in GNT_I) or mem_ready_D (in GNT_D) only; the non-granted ready SHALL stay 0.
REQ-030 SHALL drive mem_rdata_I and mem_rdata_D from mem_rdata at all times; only the ready gating selects the consumer.
REQ-031 SHALL, on mem_ready in GNT_x: clear mem_read/mem_write on the same edge, set last_gnt=x, and go to RELEASE.
REQ-032 SHALL spend exactly 1 cycle in RELEASE, ignoring all requests so that stale requests cleared by a cache are not re-granted, then return to IDLE.
REQ-033 SHALL ignore mem_ready while in IDLE or RELEASE, and no ready output SHALL pulse in those states.
REQ-034 SHALL yield a minimum turnaround of 3 cycles between consecutive grants (grant, completion, RELEASE).

Reset
REQ-035 SHALL, on proc_reset=1 at any time including mid-grant, immediately force state=IDLE, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, last_gnt=I (so D wins the first tie), busy=0, mem_ready_I=mem_ready_D=0.
REQ-036 SHALL not grant while proc_reset=1; arbitration resumes on the first rising edge after deassertion.

Verification
REQ-037 SHALL cover I-only read: mem_read_I=1, addr 0x0000010 -> next cycle mem_read=1, mem_addr=0x0000010; mem_ready after 5 cycles -> mem_ready_I pulses 1 cycle with the data, mem_ready_D stays 0.
REQ-038 SHALL cover a simultaneous tie after reset with RR_EN=1: D granted first, then I; a repeated tie alternates D, I, D.
REQ-039 SHALL cover a D write-back: mem_write_D=1, wdata 128'hA5..A5 -> mem_write=1 with the same data, mem_read=0; data unchanged until mem_ready.
REQ-040 SHALL cover a stale request: the requester holds req through the RELEASE cycle -> no second grant in RELEASE; a new grant follows only if the request persists in IDLE.
REQ-041 SHALL cover reset during GNT_D: proc_reset pulsed mid-transaction -> all memory outputs 0 asynchronously, and a later mem_ready produces no ready pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port line-request arbiter sharing one slow memory between I-cache and D-cache.
// One transaction in flight at a time; a one-cycle RELEASE gap separates consecutive grants.
module mem_arbiter #(
    parameter int unsigned RR_EN = 1
) (
    input  logic          clk,
    input  logic          proc_reset,

    input  logic          mem_read_I,
    input  logic [31:4]   mem_addr_I,
    output logic [127:0]  mem_rdata_I,
    output logic          mem_ready_I,

    input  logic          mem_read_D,
    input  logic          mem_write_D,
    input  logic [31:4]   mem_addr_D,
    input  logic [127:0]  mem_wdata_D,
    output logic [127:0]  mem_rdata_D,
    output logic          mem_ready_D,

    output logic          mem_read,
    output logic          mem_write,
    output logic [31:4]   mem_addr,
    output logic [127:0]  mem_wdata,
    input  logic [127:0]  mem_rdata,
    input  logic          mem_ready,

    output logic          busy
);

    typedef enum logic [1:0] {
        StIdle,
        StGntI,
        StGntD,
        StRelease
    } state_e;

    state_e         r_state;
    state_e         w_state_next;
    logic           r_mem_read;
    logic           r_mem_write;
    logic [31:4]    r_mem_addr;
    logic [127:0]   r_mem_wdata;
    // 1 = D side held the most recent completed grant, 0 = I side
    logic           r_last_gnt_d;

    logic           w_mem_read_next;
    logic           w_mem_write_next;
    logic [31:4]    w_mem_addr_next;
    logic [127:0]   w_mem_wdata_next;
    logic           w_last_gnt_d_next;

    logic           w_req_I;
    logic           w_req_D;
    logic           w_pick_d;

    assign w_req_I = mem_read_I;
    assign w_req_D = mem_read_D | mem_write_D;

    // D wins when it is alone, under fixed priority, or when I was served last.
    assign w_pick_d = w_req_D && (!w_req_I || (RR_EN == 0) || !r_last_gnt_d);

    always_comb begin
        w_state_next      = r_state;
        w_mem_read_next   = r_mem_read;
        w_mem_write_next  = r_mem_write;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;
        w_last_gnt_d_next = r_last_gnt_d;

        unique case (r_state)
            StIdle: begin
                if (w_req_I || w_req_D) begin
                    if (w_pick_d) begin
                        w_state_next     = StGntD;
                        // A pending write-back goes first; the read waits for a later grant.
                        w_mem_write_next = mem_write_D;
                        w_mem_read_next  = mem_read_D & ~mem_write_D;
                        w_mem_addr_next  = mem_addr_D;
                        w_mem_wdata_next = mem_wdata_D;
                    end else begin
                        w_state_next     = StGntI;
                        w_mem_write_next = 1'b0;
                        w_mem_read_next  = 1'b1;
                        w_mem_addr_next  = mem_addr_I;
                        w_mem_wdata_next = '0;
                    end
                end
            end
            StGntI, StGntD: begin
                if (mem_ready) begin
                    w_state_next      = StRelease;
                    w_mem_read_next   = 1'b0;
                    w_mem_write_next  = 1'b0;
                    w_last_gnt_d_next = (r_state == StGntD);
                end
            end
            StRelease: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_state      <= StIdle;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_last_gnt_d <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_mem_read   <= w_mem_read_next;
            r_mem_write  <= w_mem_write_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_last_gnt_d <= w_last_gnt_d_next;
        end
    end

    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign busy        = (r_state != StIdle);

    assign mem_rdata_I = mem_rdata;
    assign mem_rdata_D = mem_rdata;
    assign mem_ready_I = mem_ready && (r_state == StGntI);
    assign mem_ready_D = mem_ready && (r_state == StGntD);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, I-only read, round-robin ties, write-back,
// stale-request filtering and asynchronous reset in the middle of a D grant.
module tb_mem_arbiter;

    logic          clk;
    logic          proc_reset;
    logic          mem_read_I;
    logic [31:4]   mem_addr_I;
    logic [127:0]  mem_rdata_I;
    logic          mem_ready_I;
    logic          mem_read_D;
    logic          mem_write_D;
    logic [31:4]   mem_addr_D;
    logic [127:0]  mem_wdata_D;
    logic [127:0]  mem_rdata_D;
    logic          mem_ready_D;
    logic          mem_read;
    logic          mem_write;
    logic [31:4]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_ready;
    logic          busy;

    int n_chk;
    int n_pass;

    mem_arbiter #(.RR_EN(1)) u_dut (
        .clk         (clk),
        .proc_reset  (proc_reset),
        .mem_read_I  (mem_read_I),
        .mem_addr_I  (mem_addr_I),
        .mem_rdata_I (mem_rdata_I),
        .mem_ready_I (mem_ready_I),
        .mem_read_D  (mem_read_D),
        .mem_write_D (mem_write_D),
        .mem_addr_D  (mem_addr_D),
        .mem_wdata_D (mem_wdata_D),
        .mem_rdata_D (mem_rdata_D),
        .mem_ready_D (mem_ready_D),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Completes the current grant and walks through RELEASE back to IDLE.
    task automatic finish_grant();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        proc_reset  = 1'b1;
        mem_read_I  = 1'b0;
        mem_addr_I  = '0;
        mem_read_D  = 1'b0;
        mem_write_D = 1'b0;
        mem_addr_D  = '0;
        mem_wdata_D = '0;
        mem_rdata   = '0;
        mem_ready   = 1'b0;
        tick();
        tick();
        n_chk++; if (mem_read !== 1'b0) $display("FAIL rst_read: got %b want 0", mem_read); else n_pass++;
        n_chk++; if (mem_write !== 1'b0) $display("FAIL rst_write: got %b want 0", mem_write); else n_pass++;
        n_chk++; if (mem_addr !== 28'h0) $display("FAIL rst_addr: got %h want 0", mem_addr); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        mem_ready = 1'b1;
        #1;
        n_chk++; if ({mem_ready_I, mem_ready_D} !== 2'b00)
            $display("FAIL rst_ready: got %b want 00", {mem_ready_I, mem_ready_D}); else n_pass++;
        mem_ready  = 1'b0;
        proc_reset = 1'b0;
        tick();
    endtask

    task automatic test_i_only();
        mem_read_I = 1'b1;
        mem_addr_I = 28'h0000010;
        #1;
        n_chk++; if (mem_read !== 1'b0) $display("FAIL i_read_early: got %b want 0", mem_read); else n_pass++;
        tick();
        n_chk++; if (mem_read !== 1'b1) $display("FAIL i_read: got %b want 1", mem_read); else n_pass++;
        n_chk++; if (mem_addr !== 28'h0000010) $display("FAIL i_addr: got %h want 0000010", mem_addr); else n_pass++;
        n_chk++; if (mem_write !== 1'b0) $display("FAIL i_write: got %b want 0", mem_write); else n_pass++;
        n_chk++; if (mem_wdata !== 128'h0) $display("FAIL i_wdata: got %h want 0", mem_wdata); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL i_busy: got %b want 1", busy); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if (mem_ready_I !== 1'b0) $display("FAIL i_wait_ready: got %b want 0", mem_ready_I); else n_pass++;
        end
        mem_rdata = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        mem_ready = 1'b1;
        #1;
        n_chk++; if (mem_ready_I !== 1'b1) $display("FAIL i_ready: got %b want 1", mem_ready_I); else n_pass++;
        n_chk++; if (mem_ready_D !== 1'b0) $display("FAIL i_ready_d: got %b want 0", mem_ready_D); else n_pass++;
        n_chk++; if (mem_rdata_I !== 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D)
            $display("FAIL i_rdata: got %h want deadbeef0123456789abcdefcafef00d", mem_rdata_I); else n_pass++;
        n_chk++; if (mem_rdata_D !== 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D)
            $display("FAIL i_rdata_d: got %h want deadbeef0123456789abcdefcafef00d", mem_rdata_D); else n_pass++;
        tick();
        // mem_ready left high in RELEASE must not reach either consumer
        n_chk++; if (mem_read !== 1'b0) $display("FAIL i_rel_read: got %b want 0", mem_read); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL i_rel_busy: got %b want 1", busy); else n_pass++;
        n_chk++; if (mem_ready_I !== 1'b0) $display("FAIL i_rel_ready: got %b want 0", mem_ready_I); else n_pass++;
        mem_ready  = 1'b0;
        mem_read_I = 1'b0;
        tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL i_idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_tie();
        proc_reset = 1'b1;
        #1;
        proc_reset = 1'b0;
        mem_read_I = 1'b1;
        mem_addr_I = 28'h0000111;
        mem_read_D = 1'b1;
        mem_addr_D = 28'h0000222;
        tick();
        n_chk++; if (mem_addr !== 28'h0000222) $display("FAIL tie1_addr: got %h want 0000222", mem_addr); else n_pass++;
        mem_ready = 1'b1;
        #1;
        n_chk++; if ({mem_ready_I, mem_ready_D} !== 2'b01)
            $display("FAIL tie1_ready: got %b want 01", {mem_ready_I, mem_ready_D}); else n_pass++;
        tick();
        mem_ready = 1'b0;
        n_chk++; if (mem_read !== 1'b0) $display("FAIL tie1_rel_read: got %b want 0", mem_read); else n_pass++;
        tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL tie1_idle: got %b want 0", busy); else n_pass++;
        tick();
        n_chk++; if (mem_addr !== 28'h0000111) $display("FAIL tie2_addr: got %h want 0000111", mem_addr); else n_pass++;
        mem_ready = 1'b1;
        #1;
        n_chk++; if ({mem_ready_I, mem_ready_D} !== 2'b10)
            $display("FAIL tie2_ready: got %b want 10", {mem_ready_I, mem_ready_D}); else n_pass++;
        mem_ready = 1'b0;
        finish_grant();
        tick();
        n_chk++; if (mem_addr !== 28'h0000222) $display("FAIL tie3_addr: got %h want 0000222", mem_addr); else n_pass++;
        finish_grant();
        mem_read_I = 1'b0;
        mem_read_D = 1'b0;
        tick();
    endtask

    task automatic test_stale();
        mem_read_I = 1'b1;
        mem_addr_I = 28'h0000020;
        tick();
        n_chk++; if (mem_read !== 1'b1) $display("FAIL st_read: got %b want 1", mem_read); else n_pass++;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        n_chk++; if (mem_read !== 1'b0) $display("FAIL st_rel_read: got %b want 0", mem_read); else n_pass++;
        tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL st_no_regrant: got %b want 0", busy); else n_pass++;
        mem_read_I = 1'b0;
        tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL st_dropped: got %b want 0", busy); else n_pass++;
        mem_read_I = 1'b1;
        tick();
        n_chk++; if (mem_read !== 1'b1) $display("FAIL st_persist: got %b want 1", mem_read); else n_pass++;
        finish_grant();
        mem_read_I = 1'b0;
        tick();
    endtask

    task automatic test_writeback();
        mem_write_D = 1'b1;
        mem_read_D  = 1'b1;
        mem_addr_D  = 28'h0ABCDE0;
        mem_wdata_D = {16{8'hA5}};
        tick();
        n_chk++; if (mem_write !== 1'b1) $display("FAIL wb_write: got %b want 1", mem_write); else n_pass++;
        n_chk++; if (mem_read !== 1'b0) $display("FAIL wb_read: got %b want 0", mem_read); else n_pass++;
        n_chk++; if (mem_wdata !== {16{8'hA5}}) $display("FAIL wb_wdata: got %h want a5..a5", mem_wdata); else n_pass++;
        mem_wdata_D = '0;
        mem_addr_D  = 28'h0000444;
        repeat (3) tick();
        n_chk++; if (mem_wdata !== {16{8'hA5}}) $display("FAIL wb_hold_wdata: got %h want a5..a5", mem_wdata); else n_pass++;
        n_chk++; if (mem_addr !== 28'h0ABCDE0) $display("FAIL wb_hold_addr: got %h want 0abcde0", mem_addr); else n_pass++;
        n_chk++; if (mem_write !== 1'b1) $display("FAIL wb_hold_write: got %b want 1", mem_write); else n_pass++;
        mem_ready = 1'b1;
        tick();
        mem_ready   = 1'b0;
        mem_write_D = 1'b0;
        n_chk++; if (mem_write !== 1'b0) $display("FAIL wb_cleared: got %b want 0", mem_write); else n_pass++;
        tick();
        tick();
        // The read suppressed behind the write-back is granted now
        n_chk++; if ({mem_read, mem_write} !== 2'b10)
            $display("FAIL wb_pending_read: got %b want 10", {mem_read, mem_write}); else n_pass++;
        n_chk++; if (mem_addr !== 28'h0000444) $display("FAIL wb_pending_addr: got %h want 0000444", mem_addr); else n_pass++;
        finish_grant();
        mem_read_D = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        mem_read_D  = 1'b1;
        mem_addr_D  = 28'h0000333;
        mem_wdata_D = 128'h1234;
        tick();
        n_chk++; if (mem_read !== 1'b1) $display("FAIL rm_read: got %b want 1", mem_read); else n_pass++;
        tick();
        #2;
        proc_reset = 1'b1;
        #1;
        n_chk++; if ({mem_read, mem_write} !== 2'b00)
            $display("FAIL rm_strobes: got %b want 00", {mem_read, mem_write}); else n_pass++;
        n_chk++; if (mem_addr !== 28'h0) $display("FAIL rm_addr: got %h want 0", mem_addr); else n_pass++;
        n_chk++; if (mem_wdata !== 128'h0) $display("FAIL rm_wdata: got %h want 0", mem_wdata); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else n_pass++;
        mem_ready = 1'b1;
        #1;
        n_chk++; if ({mem_ready_I, mem_ready_D} !== 2'b00)
            $display("FAIL rm_ready: got %b want 00", {mem_ready_I, mem_ready_D}); else n_pass++;
        tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL rm_hold_busy: got %b want 0", busy); else n_pass++;
        proc_reset = 1'b0;
        #1;
        n_chk++; if (mem_ready_D !== 1'b0) $display("FAIL rm_late_ready: got %b want 0", mem_ready_D); else n_pass++;
        mem_ready  = 1'b0;
        mem_read_I = 1'b1;
        mem_addr_I = 28'h0000555;
        // Last completed grant was D, so only a cleared last_gnt lets D win this tie
        tick();
        n_chk++; if (mem_addr !== 28'h0000333) $display("FAIL rm_tie_addr: got %h want 0000333", mem_addr); else n_pass++;
        finish_grant();
        mem_read_I = 1'b0;
        mem_read_D = 1'b0;
        tick();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_i_only();
        test_tie();
        test_stale();
        test_writeback();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
